// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-domain half of the asynchronous FIFO.
// This block owns the binary and Gray write pointers. It synchronizes the
// read-domain Gray pointer through two flops. From these it derives
// registered full, almost_full, occupancy, ack and overflow for the
// write-side client and the dual-port memory.
module fifo_wr_ctrl #(
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   rd_gptr_async,
    output logic                  wr_mem_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH:0]   wr_gptr,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_count,
    output logic                  wr_ack,
    output logic                  overflow
);

    localparam int PW = ADDR_WIDTH + 1;
    // Occupancy level at which almost_full asserts.
    localparam logic [PW-1:0] AF_LEVEL  = PW'((1 << ADDR_WIDTH) - AFULL_MARGIN);
    // Inverting the top two Gray bits of the read pointer gives the write
    // pointer value that is exactly DEPTH ahead. With ADDR_WIDTH=1 this
    // inverts both bits.
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

    logic [PW-1:0] wptr_bin;
    logic [PW-1:0] wptr_bin_next;
    logic [PW-1:0] gray_next;
    logic [PW-1:0] rq1;
    logic [PW-1:0] rq2;
    logic [PW-1:0] rbin;
    logic [PW-1:0] wr_count_next;
    logic          accept;

    // The memory strobe is combinational, so the write lands on the same
    // edge that advances the pointer.
    assign accept    = wr_en & ~full;
    assign wr_mem_en = accept;
    assign wr_addr   = wptr_bin[ADDR_WIDTH-1:0];

    // Next pointer, its Gray form, and the occupancy seen through the synchronizer.
    always_comb begin
        rbin = '0;
        for (int i = 0; i < PW; i++) begin
            rbin[i] = ^(rq2 >> i);
        end
        wptr_bin_next = accept ? wptr_bin + PW'(1) : wptr_bin;
        gray_next     = wptr_bin_next ^ (wptr_bin_next >> 1);
        wr_count_next = wptr_bin_next - rbin;
    end

    // Two-flop synchronizer for the read-domain Gray pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rq1 <= '0;
            rq2 <= '0;
        end else begin
            rq1 <= rd_gptr_async;
            rq2 <= rq1;
        end
    end

    // Pointer and flag registers. All update at the edge of the accepting or rejecting cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_bin    <= '0;
            wr_gptr     <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_count    <= '0;
            wr_ack      <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            wptr_bin    <= wptr_bin_next;
            wr_gptr     <= gray_next;
            full        <= (gray_next == (rq2 ^ FULL_MASK));
            almost_full <= (wr_count_next >= AF_LEVEL);
            wr_count    <= wr_count_next;
            wr_ack      <= accept;
            overflow    <= wr_en & full;
        end
    end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl. The reference model works in unbounded write and
// read counts. Occupancy is the plain difference of those counts, against
// the read count as it stood two edges earlier.
module tb_fifo_wr_ctrl;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AFM   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW:0]   rd_gptr_async = '0;
    logic          wr_mem_en;
    logic [AW-1:0] wr_addr;
    logic [AW:0]   wr_gptr;
    logic          full;
    logic          almost_full;
    logic [AW:0]   wr_count;
    logic          wr_ack;
    logic          overflow;

    fifo_wr_ctrl #(.ADDR_WIDTH(AW), .AFULL_MARGIN(AFM)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_gptr_async(rd_gptr_async),
        .wr_mem_en(wr_mem_en), .wr_addr(wr_addr), .wr_gptr(wr_gptr),
        .full(full), .almost_full(almost_full), .wr_count(wr_count),
        .wr_ack(wr_ack), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state. w and r_cur are total writes accepted and total reads.
    // s1 and s2 hold the read count as it was one and two edges back.
    int        w, r_cur, s1, s2, m_cnt;
    bit        m_full, m_af, m_ack, m_ovf;
    bit        wrap_seen;
    logic [AW:0] prev_g;

    function automatic logic [AW:0] gray(input int b);
        logic [AW:0] v;
        v = (AW+1)'(b % (2*DEPTH));
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        w = 0; r_cur = 0; s1 = 0; s2 = 0; m_cnt = 0;
        m_full = 0; m_af = 0; m_ack = 0; m_ovf = 0;
        prev_g = '0;
    endtask

    // One clock cycle: drive inputs and check the strobe and address before the edge.
    // After the edge, update the model and compare every registered output.
    task automatic step(input bit we, input int rd);
        int occ_before;
        int seen;
        bit acc;
        wr_en = we;
        r_cur = rd;
        rd_gptr_async = gray(rd);
        #1;
        chk("wr_mem_en", wr_mem_en, we && !m_full);
        chk("wr_addr", wr_addr, w % DEPTH);
        occ_before = w - r_cur;
        @(posedge clk);
        seen = s2;
        s2 = s1;
        s1 = r_cur;
        acc   = we && !m_full;
        m_ovf = we && m_full;
        m_ack = acc;
        if (acc) w++;
        m_cnt  = w - seen;
        m_full = (m_cnt == DEPTH);
        m_af   = (m_cnt >= DEPTH - AFM);
        #1;
        chk("full", full, m_full);
        chk("almost_full", almost_full, m_af);
        chk("wr_count", wr_count, m_cnt);
        chk("wr_ack", wr_ack, m_ack);
        chk("overflow", overflow, m_ovf);
        chk("wr_gptr", wr_gptr, gray(w));
        if (wr_ack) chk("accept_while_full", occ_before < DEPTH, 1);
        if (w - r_cur == DEPTH) chk("full_optimistic", full, 1);
        chk("count_optimistic", wr_count >= (w - r_cur), 1);
        if (wr_gptr !== prev_g) begin
            chk("gray_one_bit", $countones(wr_gptr ^ prev_g), 1);
            if (prev_g == gray(2*DEPTH-1) && wr_gptr == '0) wrap_seen = 1;
        end
        prev_g = wr_gptr;
    endtask

    initial begin
        model_reset();
        wrap_seen = 0;
        #2;
        chk("rst_full", full, 0);
        chk("rst_gptr", wr_gptr, 0);
        chk("rst_count", wr_count, 0);
        chk("rst_ack", wr_ack, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_af", almost_full, 0);
        #10 rst = 1'b1;
        @(posedge clk); #1;

        // Reach wptr=5, then hit the asynchronous reset mid-cycle.
        for (int i = 0; i < 5; i++) step(1'b1, 0);
        chk("pre_reset_addr", wr_addr, 5);
        chk("pre_reset_full", full, 0);
        #2;
        rst = 1'b0;
        wr_en = 1'b0;
        #1;
        chk("async_rst_gptr", wr_gptr, 0);
        chk("async_rst_addr", wr_addr, 0);
        chk("async_rst_count", wr_count, 0);
        chk("async_rst_ack", wr_ack, 0);
        chk("async_rst_mem_en", wr_mem_en, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // Fill 16 deep with no reads. The first write lands at address 0.
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 0);
            if (i == 1)  chk("first_write_gptr", wr_gptr, 1);
            if (i == 13) chk("af_after_13", almost_full, 0);
            if (i == 14) chk("af_after_14", almost_full, 1);
            if (i == 15) chk("full_after_15", full, 0);
        end
        chk("fill_full", full, 1);
        chk("fill_count", wr_count, 16);

        // Writes attempted while full are rejected.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 0);
            chk("ovf_pulse", overflow, 1);
            chk("ovf_gptr_held", wr_gptr, 5'b11000);
            chk("ovf_mem_en", wr_mem_en, 0);
        end

        // One read becomes visible after the second edge following the change.
        step(1'b0, 1); chk("drain_k", full, 1);
        step(1'b0, 1); chk("drain_k1", full, 1);
        step(1'b0, 1); chk("drain_k2", full, 0); chk("drain_count", wr_count, 15);
        step(1'b1, 1); chk("drain_accept", wr_ack, 1); chk("refull", full, 1);

        // A write in the same cycle as a read advance is still judged against full.
        step(1'b1, 2); chk("simul_ovf", overflow, 1); chk("simul_full_k", full, 1);
        step(1'b0, 2); chk("simul_full_k1", full, 1);
        step(1'b0, 2); chk("simul_full_k2", full, 0);

        // Random interleaving of writes and reads across several pointer wraps.
        for (int n = 0; n < 2000 && w < 100; n++) begin
            int rd;
            rd = r_cur;
            if (r_cur < w && ($urandom % 2) == 0) rd = r_cur + 1;
            step(($urandom % 4) != 0, rd);
        end
        chk("random_writes", w >= 97, 1);
        chk("wrap_seen", wrap_seen, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
